fetch_if_id_stage: RTL and testbench
====================================

Name: fetch_if_id_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline. It is the direct consumer of the load-use `stall` produced by the hazard/stall handler, and it feeds the ID stage. It owns the PC, presents addresses to the asynchronous-read instruction memory, and latches {PC+4, instruction, valid} into IF/ID. It honours stall, branch/jump redirect, debug step mode and HALT detection. On HALT it drains the pipeline with NOPs before reporting halted.

Parameters:
DATA_WIDTH, 32, width of PC and instruction words
PC_RESET, 0, PC value after reset
HALT_OPCODE, 32'hFFFFFFFF, instruction encoding that stops fetch
NOP_INSTR, 32'h00000000, encoding injected on flush/drain
DRAIN_CYCLES, 4, non-stalled NOP cycles between HALT detection and halted

Ports:
clock  input  1  single system clock, rising-edge
reset  input  1  asynchronous, active-high
stall  input  1  from stall handler; freeze PC and IF/ID this cycle
redirect  input  1  branch/jump taken, resolved in ID
redirect_pc  input  DATA_WIDTH  target address for redirect
run_mode  input  1  1 = continuous run, 0 = step mode
step  input  1  single-cycle pulse; permits one advance in step mode
imem_addr  output  DATA_WIDTH  = PC register (combinational)
imem_rdata  input  DATA_WIDTH  instruction at imem_addr, same cycle
pc_plus4_id  output  DATA_WIDTH  IF/ID: PC+4 of the latched instruction
instr_id  output  DATA_WIDTH  IF/ID: instruction
valid_id  output  1  IF/ID: 1 = real instruction, 0 = bubble
halted  output  1  high in HALTED state
fetch_count  output  32  instructions accepted into IF/ID
cycle_count  output  32  clocks spent outside HALTED

Behaviour:
- Reset (async, any state, mid-drain included): PC=PC_RESET, instr_id=NOP_INSTR, pc_plus4_id=0, valid_id=0, halted=0, counters=0, drain counter=0, state=RUN.
- States: RUN, DRAIN, HALTED.
- adv = ~stall & (run_mode | step). In step mode, step held high for N cycles gives N advances.
- RUN, ~adv: PC and IF/ID hold. The redirect input is ignored when stall=1; ID re-presents it after the stall.
- RUN, adv & redirect: PC<=redirect_pc; IF/ID<=NOP_INSTR, valid 0 (flush the wrong-path fetch). No HALT check on this fetch.
- RUN, adv & ~redirect & imem_rdata==HALT_OPCODE: PC holds; IF/ID<=NOP, valid 0; drain counter<=DRAIN_CYCLES-1; state<=DRAIN.
- RUN, adv otherwise: IF/ID<={PC+4, imem_rdata, 1}; PC<=PC+4; fetch_count+1.
- DRAIN: IF/ID held at NOP/valid 0.
  - Decrement the drain counter only on ~stall cycles. run_mode/step are ignored here.
  - redirect & ~stall: the HALT was wrong-path. PC<=redirect_pc, state<=RUN, counter cleared.
  - Counter==0 & ~stall: state<=HALTED.
- HALTED: halted=1; PC and IF/ID frozen; all inputs except reset ignored; cycle_count frozen.
- Arithmetic: PC+4 and both counters wrap modulo 2^width with no saturation. HALT_OPCODE never counts in fetch_count.
- cycle_count increments every clock while state!=HALTED.
- Latency: imem_addr→IF/ID is 1 cycle. Redirect to first target instruction in IF/ID is 2 cycles (one bubble).

Test Plan:
- Continuous run, no stall, PC_RESET=0, imem_rdata=0x20080005 at every address -> IF/ID shows pc_plus4 4,8,12… with valid 1 each cycle; fetch_count=3 after 3 clocks.
- stall=1 for 2 cycles at PC=8 -> imem_addr stays 8; IF/ID holds {8, instr@4, 1}; cycle_count +2, fetch_count unchanged. With redirect=1 during the stall -> ignored.
- redirect=1, redirect_pc=0x40 at PC=0x10 -> next cycle imem_addr=0x40 and valid_id=0; following cycle IF/ID = {0x44, instr@0x40, 1}.
- imem_rdata=0xFFFFFFFF at PC=0x20, DRAIN_CYCLES=4, one stall cycle mid-drain -> valid_id=0 throughout; halted rises exactly 5 clocks after detection; PC stays 0x20; counters freeze.
- HALT fetched, then redirect=1 to 0x80 on the first drain cycle -> returns to RUN, halted never asserts, fetch resumes at 0x80. Separately, reset asserted mid-drain -> immediate reset values.
- run_mode=0, one step pulse every 3 clocks -> exactly one PC advance per pulse; cycle_count still increments every clock.

Source files
------------

// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, drives the asynchronous-read instruction memory address,
// and latches {PC+4, instruction, valid} for the decode stage. Handles
// load-use stalls, branch/jump redirects, single-step mode and a HALT
// opcode that drains the pipeline with bubbles before reporting halted.
module fetch_if_id_stage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET     = {DATA_WIDTH{1'b0}},
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE  = {DATA_WIDTH{1'b1}},
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = {DATA_WIDTH{1'b0}},
  parameter int                    DRAIN_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  run_mode,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] pc_plus4_id,
  output logic [DATA_WIDTH-1:0] instr_id,
  output logic                  valid_id,
  output logic                  halted,
  output logic [31:0]           fetch_count,
  output logic [31:0]           cycle_count
);

  // Drain counter only has to hold DRAIN_CYCLES-1.
  localparam int DCNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_RELOAD = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ZERO    = {DCNT_W{1'b0}};
  localparam logic [DCNT_W-1:0] DCNT_ONE     = {{(DCNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(32'd4);
  localparam logic [DATA_WIDTH-1:0] DW_ZERO  = {DATA_WIDTH{1'b0}};

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]            state_r, state_s;
  logic [DATA_WIDTH-1:0] pc_r, pc_s;
  logic [DATA_WIDTH-1:0] pc_plus4_r, pc_plus4_s;
  logic [DATA_WIDTH-1:0] instr_r, instr_s;
  logic                  valid_r, valid_s;
  logic [DCNT_W-1:0]     dcnt_r, dcnt_s;
  logic [31:0]           fetch_count_r, fetch_count_s;
  logic [31:0]           cycle_count_r, cycle_count_s;
  logic [DATA_WIDTH-1:0] pc_inc_s;
  logic                  adv_s;

  // Next-state, PC and IF/ID update decisions for the fetch FSM.
  always_comb begin
    adv_s         = ~stall & (run_mode | step);
    pc_inc_s      = pc_r + PC_STEP;
    state_s       = state_r;
    pc_s          = pc_r;
    pc_plus4_s    = pc_plus4_r;
    instr_s       = instr_r;
    valid_s       = valid_r;
    dcnt_s        = dcnt_r;
    fetch_count_s = fetch_count_r;
    if (state_r != ST_HALTED) begin
      cycle_count_s = cycle_count_r + 32'd1;
    end else begin
      cycle_count_s = cycle_count_r;
    end

    case (state_r)
      ST_RUN: begin
        if (adv_s) begin
          if (redirect) begin
            // Wrong-path fetch is squashed; no HALT check on it.
            pc_s       = redirect_pc;
            pc_plus4_s = DW_ZERO;
            instr_s    = NOP_INSTR;
            valid_s    = 1'b0;
          end else if (imem_rdata == HALT_OPCODE) begin
            // PC parks on the HALT so a later resume points at it.
            pc_s       = pc_r;
            pc_plus4_s = DW_ZERO;
            instr_s    = NOP_INSTR;
            valid_s    = 1'b0;
            dcnt_s     = DRAIN_RELOAD;
            state_s    = ST_DRAIN;
          end else begin
            pc_s          = pc_inc_s;
            pc_plus4_s    = pc_inc_s;
            instr_s       = imem_rdata;
            valid_s       = 1'b1;
            fetch_count_s = fetch_count_r + 32'd1;
          end
        end else begin
          pc_s = pc_r;
        end
      end

      ST_DRAIN: begin
        instr_s = NOP_INSTR;
        valid_s = 1'b0;
        if (~stall) begin
          if (redirect) begin
            // The HALT sat on a mispredicted path: resume at the target.
            pc_s    = redirect_pc;
            dcnt_s  = DCNT_ZERO;
            state_s = ST_RUN;
          end else if (dcnt_r == DCNT_ZERO) begin
            state_s = ST_HALTED;
          end else begin
            dcnt_s = dcnt_r - DCNT_ONE;
          end
        end else begin
          dcnt_s = dcnt_r;
        end
      end

      ST_HALTED: begin
        state_s = ST_HALTED;
      end

      default: begin
        // Unreachable encoding: fall back to a clean bubble in RUN.
        state_s = ST_RUN;
        instr_s = NOP_INSTR;
        valid_s = 1'b0;
        dcnt_s  = DCNT_ZERO;
      end
    endcase
  end

  // State, PC, IF/ID register and counters with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_RUN;
      pc_r          <= PC_RESET;
      pc_plus4_r    <= DW_ZERO;
      instr_r       <= NOP_INSTR;
      valid_r       <= 1'b0;
      dcnt_r        <= DCNT_ZERO;
      fetch_count_r <= 32'd0;
      cycle_count_r <= 32'd0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      pc_plus4_r    <= pc_plus4_s;
      instr_r       <= instr_s;
      valid_r       <= valid_s;
      dcnt_r        <= dcnt_s;
      fetch_count_r <= fetch_count_s;
      cycle_count_r <= cycle_count_s;
    end
  end

  assign imem_addr   = pc_r;
  assign pc_plus4_id = pc_plus4_r;
  assign instr_id    = instr_r;
  assign valid_id    = valid_r;
  assign halted      = (state_r == ST_HALTED);
  assign fetch_count = fetch_count_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Scoreboard testbench for fetch_if_id_stage: the stimulus thread pushes
// every expected IF/ID instruction, a monitor pops and compares each time
// the stage accepts a new instruction; direct checks cover PC, halt and
// counter behaviour.
module tb_fetch_if_id_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        run_mode;
  logic        step;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_plus4_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] cycle_count;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_ticks  = 0;
  int          n_halt   = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_fc  = 32'd0;

  // Instruction memory model
  logic        const_mode;
  logic        halt_en;
  logic [31:0] halt_addr;

  fetch_if_id_stage dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .run_mode    (run_mode),
    .step        (step),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc_plus4_id (pc_plus4_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id),
    .halted      (halted),
    .fetch_count (fetch_count),
    .cycle_count (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
    if (const_mode) return 32'h2008_0005;
    return {16'h2408, a[15:0]};
  endfunction

  // Combinational instruction memory read.
  always_comb imem_rdata = instr_at(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc4, input logic [31:0] ins);
    exp_t e;
    e.pc4   = pc4;
    e.instr = ins;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    n_ticks++;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"},   imem_addr,           32'd0);
    chk({tag, "_valid"},  {31'd0, valid_id},   32'd0);
    chk({tag, "_instr"},  instr_id,            32'd0);
    chk({tag, "_pc4"},    pc_plus4_id,         32'd0);
    chk({tag, "_halted"}, {31'd0, halted},     32'd0);
    chk({tag, "_fc"},     fetch_count,         32'd0);
    chk({tag, "_cc"},     cycle_count,         32'd0);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    run_mode    = 1'b1;
    step        = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_reset_values("rst");
    reset   = 1'b0;
    n_ticks = 0;
  endtask

  // Monitor: each newly accepted instruction is popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (valid_id && fetch_count !== last_fc) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got pc4 0x%08h instr 0x%08h expected none", pc_plus4_id, instr_id);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_pc4",   pc_plus4_id, e.pc4);
            chk("sb_instr", instr_id,    e.instr);
          end
        end
      end
      last_fc = fetch_count;
    end
  end

  initial begin
    const_mode = 1'b1;
    halt_en    = 1'b0;
    halt_addr  = 32'd0;
    do_reset();

    // Continuous run with a constant instruction
    push(32'd4, 32'h2008_0005); tick();
    push(32'd8, 32'h2008_0005); tick();
    chk("run_addr", imem_addr, 32'd8);
    chk("run_fc",   fetch_count, 32'd2);

    // Two stall cycles at PC=8; redirect during stall is ignored
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    tick(); tick();
    chk("stall_addr",  imem_addr,         32'd8);
    chk("stall_pc4",   pc_plus4_id,       32'd8);
    chk("stall_instr", instr_id,          32'h2008_0005);
    chk("stall_valid", {31'd0, valid_id}, 32'd1);
    chk("stall_fc",    fetch_count,       32'd2);
    chk("stall_cc",    cycle_count,       32'd4);
    stall = 1'b0; redirect = 1'b0;
    push(32'd12, 32'h2008_0005); tick();
    chk("resume_fc",   fetch_count, 32'd3);
    chk("resume_addr", imem_addr,   32'd12);
    chk("resume_cc",   cycle_count, 32'd5);

    // Redirect at PC=0x10 to 0x40: one bubble, then target instruction
    const_mode = 1'b0;
    push(32'h10, 32'h2408_000C); tick();
    chk("pre_redir_addr", imem_addr, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("redir_addr",  imem_addr,         32'h40);
    chk("redir_valid", {31'd0, valid_id}, 32'd0);
    redirect = 1'b0;
    push(32'h44, 32'h2408_0040); tick();
    chk("redir_tgt_valid", {31'd0, valid_id}, 32'd1);

    // Move to 0x20 via redirect to 0x1C, then fetch HALT at 0x20
    redirect = 1'b1; redirect_pc = 32'h1C; tick();
    redirect = 1'b0;
    push(32'h20, 32'h2408_001C); tick();
    chk("pre_halt_fc", fetch_count, 32'd6);
    halt_en = 1'b1; halt_addr = 32'h20;
    tick();
    chk("halt_det_valid",  {31'd0, valid_id}, 32'd0);
    chk("halt_det_addr",   imem_addr,         32'h20);
    chk("halt_det_halted", {31'd0, halted},   32'd0);
    for (int i = 1; i <= 5; i++) begin
      stall = (i == 2) ? 1'b1 : 1'b0;
      tick();
      chk("drain_valid",  {31'd0, valid_id}, 32'd0);
      chk("drain_addr",   imem_addr,         32'h20);
      chk("drain_halted", {31'd0, halted},   (i == 5) ? 32'd1 : 32'd0);
    end
    stall  = 1'b0;
    n_halt = n_ticks;
    chk("halt_cc", cycle_count, n_halt);
    // All inputs ignored once halted
    redirect = 1'b1; redirect_pc = 32'h200; step = 1'b1; halt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted_hold",  {31'd0, halted},   32'd1);
      chk("halted_addr",  imem_addr,         32'h20);
      chk("halted_cc",    cycle_count,       n_halt);
      chk("halted_fc",    fetch_count,       32'd6);
      chk("halted_valid", {31'd0, valid_id}, 32'd0);
    end

    // HALT on a wrong path, cancelled by redirect in the first drain cycle
    do_reset();
    halt_en = 1'b1; halt_addr = 32'h8;
    push(32'd4, 32'h2408_0000); tick();
    push(32'd8, 32'h2408_0004); tick();
    tick();
    chk("wp_det_valid", {31'd0, valid_id}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    chk("wp_addr",   imem_addr,         32'h80);
    chk("wp_halted", {31'd0, halted},   32'd0);
    chk("wp_valid",  {31'd0, valid_id}, 32'd0);
    chk("wp_fc",     fetch_count,       32'd2);
    redirect = 1'b0;
    push(32'h84, 32'h2408_0080); tick();
    chk("wp_res_valid",  {31'd0, valid_id}, 32'd1);
    chk("wp_res_fc",     fetch_count,       32'd3);
    chk("wp_res_halted", {31'd0, halted},   32'd0);

    // Reset asserted mid-drain
    halt_addr = 32'h84;
    tick();
    chk("md_addr", imem_addr, 32'h84);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("md_rst");
    halt_en = 1'b0;
    @(negedge clock);
    reset   = 1'b0;
    n_ticks = 0;
    push(32'd4, 32'h2408_0000); tick();
    chk("post_rst_addr", imem_addr, 32'd4);

    // Step mode: one pulse every three clocks
    run_mode = 1'b0;
    exp_pc   = 32'd4;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      push(exp_pc + 32'd4, instr_at(exp_pc));
      tick();
      exp_pc = exp_pc + 32'd4;
      chk("step_adv", imem_addr, exp_pc);
      step = 1'b0;
      tick();
      chk("step_hold1", imem_addr, exp_pc);
      tick();
      chk("step_hold2", imem_addr, exp_pc);
      chk("step_cc",    cycle_count, n_ticks);
    end
    // step held two cycles gives two advances
    step = 1'b1;
    push(32'h14, 32'h2408_0010); tick();
    push(32'h18, 32'h2408_0014); tick();
    step = 1'b0;
    tick();
    chk("step2_addr", imem_addr,   32'h18);
    chk("step2_fc",   fetch_count, 32'd6);

    tick();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
